dac7611_serial_rx: RTL and testbench
====================================

Name: dac7611_serial_rx

Overview:
- Receive-side counterpart of the DAC7611 serial write path: a receiver/monitor that decodes the same 4-wire bus, {CLK, SDI, LD, CLR}, as dac_signals_4[3:0].
- Oversamples the bus on the system clock, shifts SDI MSB-first on CLK rising edges, and latches the 12-bit code on LD assertion.
- Reports frame errors and CLR events.
- Used on-board for loopback checking of the DAC driver and as a bit-true DAC model in system benches.

Parameters:
- DATA_BITS, 12, serial word length (MSB first).
- SYNC_STAGES, 2, synchronizer flops per bus input (minimum 2).
- CNT_W, 16, width of the good-frame counter.

Ports:
- clk  input  1  system clock; at least 2x the serial CLK rate.
- reset  input  1  asynchronous, active-low reset.
- dac_signals_4  input  4  bit3 CLK, bit2 SDI, bit1 LD (active low), bit0 CLR (active low).
- dac_code  output  DATA_BITS  last latched code.
- code_valid  output  1  1-cycle pulse when dac_code updates from a good frame.
- frame_err  output  1  1-cycle pulse when LD is asserted with bit count != DATA_BITS.
- clr_seen  output  1  1-cycle pulse on CLR assertion.
- frame_cnt  output  CNT_W  count of good frames; saturating.
- busy  output  1  high while in SHIFT or LOADED.

Behaviour:
- Reset (reset=0, async): dac_code=0, code_valid=0, frame_err=0, clr_seen=0, frame_cnt=0, busy=0, shift register=0, bit_cnt=0, state=IDLE.
- Synchronizer reset values: CLK=1, SDI=0, LD=1, CLR=1, so no false edges after reset release.
- Input path: each bus bit passes SYNC_STAGES flops, then one edge-detect flop.
  - Events: clk_rise, ld_fall, ld_rise, clr_fall.
  - All outputs update SYNC_STAGES+1 clk cycles after the bus transition is first sampled.
- Shift register update on clk_rise: shift_reg <= {shift_reg[DATA_BITS-2:0], SDI_sync}.
  - SDI_sync is the value at the same synchronized sample as the CLK rise.
  - bit_cnt increments and saturates at DATA_BITS+1.
  - Bits beyond DATA_BITS are shifted in (oldest bits lost) and mark the frame long.
- States:
  - IDLE: bit_cnt=0, busy=0. clk_rise -> SHIFT. ld_fall -> frame_err pulse, go to LOADED; dac_code is not changed.
  - SHIFT: clk_rise continues shifting. ld_fall evaluates bit_cnt:
    - bit_cnt==DATA_BITS: dac_code <= shift_reg, code_valid pulse, frame_cnt+1 (saturating at all-ones).
    - otherwise: dac_code <= shift_reg (matches DAC latch behaviour), frame_err pulse, frame_cnt unchanged.
    - Either case: go to LOADED.
  - LOADED: CLK rises are ignored and do not shift. ld_rise -> IDLE, bit_cnt=0, shift_reg kept.
- CLR handling:
  - clr_fall in any state: dac_code <= 0, clr_seen pulse; state and shift_reg untouched.
  - CLR held low: dac_code is forced to 0 every cycle and code_valid is suppressed; shift/LD tracking continues.
- Simultaneous events in one cycle:
  - clr_fall with ld_fall: CLR wins for dac_code (0), clr_seen=1, code_valid=0. frame_err and frame_cnt still evaluated as normal.
  - clk_rise with ld_fall in SHIFT: shift first, then evaluate the count including that bit.
- Pulse outputs are registered, exactly one cycle high, and never asserted during reset.
- Reset mid-frame: everything returns to reset values immediately. A subsequent ld_fall without any CLK rise gives frame_err.

Decomposition:
- Shared package dac_pkg:
  - DAC_BITS=12.
  - Bus bit indices: DAC_CLK=3, DAC_SDI=2, DAC_LD=1, DAC_CLR=0.
  - State encoding (IDLE, SHIFT, LOADED).
- One sub-module, sync_edge_det: parameterised SYNC_STAGES flop chain with reset value input, producing a synced level plus rise and fall pulses. Instantiated once per bus bit.

Test Plan:
- Frame 0x555 (SDI 0,1,0,1... MSB first, 12 CLK pulses, CLK low/high 2 clk each), then LD low 2 clk -> dac_code=0x555, one code_valid pulse, frame_cnt=1, frame_err=0.
- Frame 0xA3C followed by 0x001 back-to-back, LD between them -> dac_code 0xA3C then 0x001, frame_cnt=2, two code_valid pulses.
- 11-bit frame, then LD low -> frame_err pulse, no code_valid, frame_cnt unchanged.
- 13-bit frame 1,0x555, then LD low -> frame_err pulse, dac_code=0x555.
- After 0x555 loaded, CLR low for 1 clk -> dac_code=0x000, clr_seen pulse. CLR and LD fall in the same cycle -> dac_code=0, code_valid=0.
- reset=0 after 6 bits shifted, release, then LD low -> all outputs 0 during reset, then a frame_err pulse.
- CLK toggling while LD low (LOADED) -> no shift, dac_code stable.

Source files
------------

// File: rtl/dac_pkg.sv
// ------------------------------------------------------------------
// dac_pkg : shared constants and state encoding for the DAC7611 bus
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package dac_pkg;

  localparam int DAC_BITS = 12;

  localparam int DAC_CLK = 3;
  localparam int DAC_SDI = 2;
  localparam int DAC_LD  = 1;
  localparam int DAC_CLR = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_LOADED = 2'd2
  } dac_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ------------------------------------------------------------------
// sync_edge_det : N-stage synchronizer with registered edge detection
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sync_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Reset to the bus idle level so release never fakes an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

`default_nettype wire

// File: rtl/dac7611_serial_rx.sv
// ------------------------------------------------------------------
// dac7611_serial_rx : DAC7611 4-wire bus receiver / bit-true DAC model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module dac7611_serial_rx
  import dac_pkg::*;
#(
  parameter int DATA_BITS   = DAC_BITS,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           dac_signals_4,
  output logic [DATA_BITS-1:0] dac_code,
  output logic                 code_valid,
  output logic                 frame_err,
  output logic                 clr_seen,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 busy
);

  localparam int             BCW        = $clog2(DATA_BITS + 2);
  localparam logic [BCW-1:0] C_CNT_FULL = BCW'(DATA_BITS);
  localparam logic [BCW-1:0] C_CNT_SAT  = BCW'(DATA_BITS + 1);

  logic [3:0] w_lvl;
  logic [3:0] w_rise;
  logic [3:0] w_fall;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (gi != DAC_SDI)
    ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_d     (dac_signals_4[gi]),
      .o_level (w_lvl[gi]),
      .o_rise  (w_rise[gi]),
      .o_fall  (w_fall[gi])
    );
  end

  logic w_clk_rise, w_ld_fall, w_ld_rise, w_clr_fall, w_clr_lvl, w_sdi;
  assign w_clk_rise = w_rise[DAC_CLK];
  assign w_ld_fall  = w_fall[DAC_LD];
  assign w_ld_rise  = w_rise[DAC_LD];
  assign w_clr_fall = w_fall[DAC_CLR];
  assign w_clr_lvl  = w_lvl[DAC_CLR];
  assign w_sdi      = w_lvl[DAC_SDI];

  logic w_unused;
  assign w_unused = ^{w_lvl[DAC_CLK], w_lvl[DAC_LD], w_rise[DAC_SDI], w_rise[DAC_CLR],
                      w_fall[DAC_CLK], w_fall[DAC_SDI]};

  dac_state_t           r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BCW-1:0]       r_bit_cnt;

  // Shift/count as seen after this cycle's CLK rise, so a coincident LD fall counts that bit
  logic                 w_shift_en;
  logic [DATA_BITS-1:0] w_sh_nxt;
  logic [BCW-1:0]       w_cnt_inc;
  logic [BCW-1:0]       w_cnt_nxt;

  assign w_shift_en = w_clk_rise && (r_state != ST_LOADED);
  assign w_sh_nxt   = w_shift_en ? {r_shift[DATA_BITS-2:0], w_sdi} : r_shift;
  assign w_cnt_inc  = (r_bit_cnt == C_CNT_SAT) ? r_bit_cnt : r_bit_cnt + BCW'(1);
  assign w_cnt_nxt  = w_shift_en ? w_cnt_inc : r_bit_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      dac_code   <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      clr_seen   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      clr_seen   <= w_clr_fall;
      r_shift    <= w_sh_nxt;
      r_bit_cnt  <= w_cnt_nxt;
      case (r_state)
        ST_IDLE, ST_SHIFT: begin
          if (w_ld_fall) begin
            r_state <= ST_LOADED;
            if (w_cnt_nxt == C_CNT_FULL) begin
              dac_code   <= w_sh_nxt;
              code_valid <= w_clr_lvl;
              if (frame_cnt != {CNT_W{1'b1}}) frame_cnt <= frame_cnt + CNT_W'(1);
            end else begin
              frame_err <= 1'b1;
              if (w_cnt_nxt != '0) dac_code <= w_sh_nxt;
            end
          end else if (w_shift_en) begin
            r_state <= ST_SHIFT;
          end
        end
        ST_LOADED: begin
          if (w_ld_rise) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (!w_clr_lvl) dac_code <= '0;
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dac7611_serial_rx.sv
// ------------------------------------------------------------------
// tb_dac7611_serial_rx : scoreboard bench for the DAC7611 bus receiver
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_dac7611_serial_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        b_clk = 1'b1, b_sdi = 1'b0, b_ld = 1'b1, b_clr = 1'b1;
  logic [3:0]  bus;
  logic [11:0] dac_code;
  logic        code_valid, frame_err, clr_seen, busy;
  logic [15:0] frame_cnt;

  assign bus = {b_clk, b_sdi, b_ld, b_clr};

  always #5 clk = ~clk;

  dac7611_serial_rx #(.DATA_BITS(12), .SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .dac_signals_4 (bus),
    .dac_code      (dac_code),
    .code_valid    (code_valid),
    .frame_err     (frame_err),
    .clr_seen      (clr_seen),
    .frame_cnt     (frame_cnt),
    .busy          (busy)
  );

  int          n_assert = 0;
  int          n_fail = 0;
  int          n_valid = 0, n_err = 0, n_clr = 0;
  int          v0, e0, c0;
  logic [15:0] exp_cnt = 16'd0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_code;

  // Output monitor: pops the scoreboard on every code_valid pulse
  always @(negedge clk) begin
    if (!reset) begin
      if (code_valid || frame_err || clr_seen) begin
        n_assert++;
        n_fail++;
        $display("FAIL pulse_in_reset got=%b%b%b exp=000", code_valid, frame_err, clr_seen);
      end
    end else begin
      if (code_valid) begin
        n_valid++;
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_code_valid got=%h exp=none", dac_code);
        end else begin
          exp_code = exp_q.pop_front();
          if (dac_code !== exp_code) begin
            n_fail++;
            $display("FAIL scoreboard_code got=%h exp=%h", dac_code, exp_code);
          end
        end
      end
      if (frame_err) n_err++;
      if (clr_seen) n_clr++;
    end
  end

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk); b_clk = 1'b0; b_sdi = v[i];
      @(negedge clk);
      @(negedge clk); b_clk = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic pulse_ld();
    @(negedge clk); b_ld = 1'b0;
    repeat (2) @(negedge clk);
    b_ld = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic snap();
    v0 = n_valid; e0 = n_err; c0 = n_clr;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_assert++; if (dac_code !== 12'h000) begin n_fail++; $display("FAIL rst_code got=%h exp=000", dac_code); end
    n_assert++; if (frame_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt got=%h exp=0", frame_cnt); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
    n_assert++; if (n_valid + n_err + n_clr != 0) begin n_fail++; $display("FAIL post_rst_pulses got=%0d exp=0", n_valid + n_err + n_clr); end
  endtask

  task automatic test_frame_555();
    snap();
    exp_q.push_back(12'h555);
    send_bits(16'h555, 12);
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL shift_busy got=%b exp=1", busy); end
    pulse_ld();
    exp_cnt++;
    n_assert++; if (dac_code !== 12'h555) begin n_fail++; $display("FAIL f555_code got=%h exp=555", dac_code); end
    n_assert++; if (n_valid - v0 != 1) begin n_fail++; $display("FAIL f555_valid got=%0d exp=1", n_valid - v0); end
    n_assert++; if (n_err != e0) begin n_fail++; $display("FAIL f555_err got=%0d exp=0", n_err - e0); end
    n_assert++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL f555_cnt got=%h exp=%h", frame_cnt, exp_cnt); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    snap();
    exp_q.push_back(12'hA3C);
    send_bits(16'hA3C, 12);
    pulse_ld();
    n_assert++; if (dac_code !== 12'hA3C) begin n_fail++; $display("FAIL b2b_code1 got=%h exp=a3c", dac_code); end
    exp_q.push_back(12'h001);
    send_bits(16'h001, 12);
    pulse_ld();
    exp_cnt += 2;
    n_assert++; if (dac_code !== 12'h001) begin n_fail++; $display("FAIL b2b_code2 got=%h exp=001", dac_code); end
    n_assert++; if (n_valid - v0 != 2) begin n_fail++; $display("FAIL b2b_valid got=%0d exp=2", n_valid - v0); end
    n_assert++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt got=%h exp=%h", frame_cnt, exp_cnt); end
  endtask

  task automatic test_short();
    // shift reg still holds 0x001, so its LSB survives at bit 11
    snap();
    send_bits(16'h2AB, 11);
    pulse_ld();
    n_assert++; if (n_err - e0 != 1) begin n_fail++; $display("FAIL short_err got=%0d exp=1", n_err - e0); end
    n_assert++; if (n_valid != v0) begin n_fail++; $display("FAIL short_valid got=%0d exp=0", n_valid - v0); end
    n_assert++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL short_cnt got=%h exp=%h", frame_cnt, exp_cnt); end
    n_assert++; if (dac_code !== 12'hAAB) begin n_fail++; $display("FAIL short_code got=%h exp=aab", dac_code); end
  endtask

  task automatic test_long();
    snap();
    send_bits(16'h1555, 13);
    pulse_ld();
    n_assert++; if (n_err - e0 != 1) begin n_fail++; $display("FAIL long_err got=%0d exp=1", n_err - e0); end
    n_assert++; if (dac_code !== 12'h555) begin n_fail++; $display("FAIL long_code got=%h exp=555", dac_code); end
    n_assert++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL long_cnt got=%h exp=%h", frame_cnt, exp_cnt); end
  endtask

  task automatic test_clr();
    exp_q.push_back(12'h555);
    send_bits(16'h555, 12);
    pulse_ld();
    exp_cnt++;
    snap();
    @(negedge clk); b_clr = 1'b0;
    @(negedge clk); b_clr = 1'b1;
    repeat (6) @(negedge clk);
    n_assert++; if (dac_code !== 12'h000) begin n_fail++; $display("FAIL clr_code got=%h exp=000", dac_code); end
    n_assert++; if (n_clr - c0 != 1) begin n_fail++; $display("FAIL clr_seen got=%0d exp=1", n_clr - c0); end
    // CLR and LD falling together on a good frame
    send_bits(16'h3C3, 12);
    snap();
    @(negedge clk); b_clr = 1'b0; b_ld = 1'b0;
    @(negedge clk); b_clr = 1'b1;
    @(negedge clk); b_ld = 1'b1;
    repeat (6) @(negedge clk);
    exp_cnt++;
    n_assert++; if (dac_code !== 12'h000) begin n_fail++; $display("FAIL clrld_code got=%h exp=000", dac_code); end
    n_assert++; if (n_valid != v0) begin n_fail++; $display("FAIL clrld_valid got=%0d exp=0", n_valid - v0); end
    n_assert++; if (n_clr - c0 != 1) begin n_fail++; $display("FAIL clrld_seen got=%0d exp=1", n_clr - c0); end
    n_assert++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL clrld_cnt got=%h exp=%h", frame_cnt, exp_cnt); end
  endtask

  task automatic test_reset_midframe();
    send_bits(16'h02D, 6);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    n_assert++; if (dac_code !== 12'h000) begin n_fail++; $display("FAIL mrst_code got=%h exp=000", dac_code); end
    n_assert++; if (frame_cnt !== 16'h0) begin n_fail++; $display("FAIL mrst_cnt got=%h exp=0", frame_cnt); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy got=%b exp=0", busy); end
    @(negedge clk); reset = 1'b1;
    exp_cnt = 16'h0;
    repeat (4) @(negedge clk);
    snap();
    pulse_ld();
    n_assert++; if (n_err - e0 != 1) begin n_fail++; $display("FAIL mrst_err got=%0d exp=1", n_err - e0); end
    n_assert++; if (dac_code !== 12'h000) begin n_fail++; $display("FAIL mrst_ld_code got=%h exp=000", dac_code); end
    n_assert++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL mrst_ld_cnt got=%h exp=%h", frame_cnt, exp_cnt); end
  endtask

  task automatic test_loaded_ignore();
    snap();
    exp_q.push_back(12'h5A5);
    send_bits(16'h5A5, 12);
    @(negedge clk); b_ld = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(16'h00F, 4);
    repeat (4) @(negedge clk);
    exp_cnt++;
    n_assert++; if (dac_code !== 12'h5A5) begin n_fail++; $display("FAIL loaded_code got=%h exp=5a5", dac_code); end
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL loaded_busy got=%b exp=1", busy); end
    n_assert++; if (n_valid - v0 != 1) begin n_fail++; $display("FAIL loaded_valid got=%0d exp=1", n_valid - v0); end
    b_ld = 1'b1;
    repeat (6) @(negedge clk);
    // a 4-bit frame of zeros exposes whether LOADED clocks disturbed the shift register
    snap();
    send_bits(16'h000, 4);
    pulse_ld();
    n_assert++; if (dac_code !== 12'hA50) begin n_fail++; $display("FAIL loaded_shift got=%h exp=a50", dac_code); end
    n_assert++; if (n_err - e0 != 1) begin n_fail++; $display("FAIL loaded_err got=%0d exp=1", n_err - e0); end
    chk("final_cnt", frame_cnt, exp_cnt);
  endtask

  initial begin
    test_reset();
    test_frame_555();
    test_back_to_back();
    test_short();
    test_long();
    test_clr();
    test_reset_midframe();
    test_loaded_ignore();
    repeat (4) @(negedge clk);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
